ad9228_fifo_drain_sched: RTL and testbench

Round-robin scheduler that drains the per-channel sample FIFOs of the AD9228 readout block through its shared, address-muxed FIFO read port. It serialises the samples into a single tagged valid/ready stream for the downstream packetiser. The block runs entirely in the FIFO read-clock domain and sits between the ADC readout block and the board data path.

---
 rtl/ad9228_fifo_drain_sched_pkg.sv | 17 +
 rtl/ad9228_fifo_drain_sched_if.sv | 37 +++
 rtl/ad9228_fifo_drain_sched_rr_pick.sv | 32 +++
 rtl/ad9228_fifo_drain_sched.sv | 166 ++++++++++++++++
 tb/tb_ad9228_fifo_drain_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ad9228_fifo_drain_sched_pkg.sv
// Shared types and defaults for the AD9228 FIFO drain scheduler.
// Optional overflow capture is enabled by AD9228_DRAIN_OVF_EN.
package ad9228_pkg;

  localparam int AD9228_NUM_CHANNELS = 4;
  localparam int AD9228_DATA_WIDTH   = 12;
  localparam int AD9228_CH_W         = $clog2(AD9228_NUM_CHANNELS);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    CHECK,
    WAIT,
    HOLD
  } state_e;

endpackage

// File: rtl/ad9228_fifo_drain_sched_if.sv
// Readout FIFO read port plus the tagged sample stream.
// master = scheduler side, slave = readout/packetiser side.
interface ad9228_fifo_drain_sched_if
  import ad9228_pkg::*;
#(
  parameter int NUM_CHANNELS = AD9228_NUM_CHANNELS,
  parameter int DATA_WIDTH   = AD9228_DATA_WIDTH
);

  localparam int CW = $clog2(NUM_CHANNELS);

  logic [CW-1:0]           fifo_addr;
  logic [NUM_CHANNELS-1:0] fifo_rd_en;
  logic                    fifo_not_empty;
  logic                    fifo_full;
  logic [DATA_WIDTH-1:0]   fifo_dout;
  logic [DATA_WIDTH-1:0]   m_data;
  logic [CW-1:0]           m_chan;
  logic                    m_last;
  logic                    m_valid;
  logic                    m_ready;

  modport master (
    output fifo_addr, fifo_rd_en,
    input  fifo_not_empty, fifo_full, fifo_dout,
    output m_data, m_chan, m_last, m_valid,
    input  m_ready
  );

  modport slave (
    input  fifo_addr, fifo_rd_en,
    output fifo_not_empty, fifo_full, fifo_dout,
    input  m_data, m_chan, m_last, m_valid,
    output m_ready
  );

endinterface

// File: rtl/ad9228_fifo_drain_sched_rr_pick.sv
// Cyclic first-set search over the channel mask,
// starting one above the round-robin pointer.
module ad9228_rr_pick
  import ad9228_pkg::*;
#(
  parameter int NUM_CHANNELS = AD9228_NUM_CHANNELS
) (
  input  logic [NUM_CHANNELS-1:0]         mask_i,
  input  logic [$clog2(NUM_CHANNELS)-1:0] ptr_i,
  output logic [$clog2(NUM_CHANNELS)-1:0] ch_o,
  output logic                            found_o
);

  localparam int CW = $clog2(NUM_CHANNELS);

  // lowest set bit at or after ptr+1, wrapping
  always_comb begin
    int idx;
    idx     = 0;
    ch_o    = '0;
    found_o = 1'b0;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= NUM_CHANNELS) idx -= NUM_CHANNELS;
      if (!found_o && mask_i[idx]) begin
        found_o = 1'b1;
        ch_o    = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/ad9228_fifo_drain_sched.sv
// Round-robin drain of the AD9228 per-channel FIFOs into one stream.
// Define AD9228_DRAIN_OVF_EN to build the sticky FIFO-full flags.
module ad9228_fifo_drain_sched
  import ad9228_pkg::*;
#(
  parameter int NUM_CHANNELS = AD9228_NUM_CHANNELS,
  parameter int DATA_WIDTH   = AD9228_DATA_WIDTH,
  parameter int BURST_LEN    = 4,
  parameter int RD_LATENCY   = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enable,
  input  logic [NUM_CHANNELS-1:0] ch_mask,
  input  logic                    ovf_clr,
  output logic                    busy,
  output logic [NUM_CHANNELS-1:0] ovf_flags,
  ad9228_fifo_drain_sched_if.master bus
);

  localparam int CW = $clog2(NUM_CHANNELS);
  localparam int NW = $clog2(BURST_LEN + 1);
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [NW-1:0] BL_C    = NW'(BURST_LEN);
  localparam logic [NW-1:0] BL_M1   = NW'(BURST_LEN - 1);
  localparam logic [LW-1:0] LAT_M1  = LW'(RD_LATENCY - 1);
  localparam logic [CW-1:0] PTR_RST = CW'(NUM_CHANNELS - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           ptr_q, ptr_d;
  logic [CW-1:0]           addr_q, addr_d;
  logic [CW-1:0]           chan_q, chan_d;
  logic [NW-1:0]           cnt_q, cnt_d;
  logic [LW-1:0]           lat_q, lat_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    last_q, last_d;
  logic                    valid_q, valid_d;
  logic [NUM_CHANNELS-1:0] rd_en;
  logic [CW-1:0]           pick_ch;
  logic                    pick_found;

  ad9228_rr_pick #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_pick (
    .mask_i (ch_mask),
    .ptr_i  (ptr_q),
    .ch_o   (pick_ch),
    .found_o(pick_found)
  );

  // next-state, read strobe and capture decisions
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    rd_en   = '0;
    unique case (state_q)
      IDLE: begin
        if (enable && (|ch_mask)) state_d = ARB;
      end
      ARB: begin
        if (pick_found) begin
          addr_d  = pick_ch;
          ptr_d   = pick_ch;
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (cnt_q == BL_C || !bus.fifo_not_empty) begin
          state_d = ARB;
        end else begin
          rd_en[addr_q] = 1'b1;
          lat_d         = '0;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == LAT_M1) begin
          data_d  = bus.fifo_dout;
          chan_d  = addr_q;
          last_d  = (cnt_q == BL_M1);
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + NW'(1);
          state_d = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // scheduler state and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      addr_q  <= '0;
      chan_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign bus.fifo_addr  = addr_q;
  assign bus.fifo_rd_en = rd_en;
  assign bus.m_data     = data_q;
  assign bus.m_chan     = chan_q;
  assign bus.m_last     = last_q;
  assign bus.m_valid    = valid_q;
  assign busy           = (state_q != IDLE);

`ifdef AD9228_DRAIN_OVF_EN
  logic [NUM_CHANNELS-1:0] ovf_q, ovf_d;

  // clear first so a same-cycle full flag still sets its bit
  always_comb begin
    ovf_d = ovf_clr ? '0 : ovf_q;
    if (bus.fifo_full) ovf_d[addr_q] = 1'b1;
  end

  // sticky overflow flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_flags = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_clr ^ bus.fifo_full;
  assign ovf_flags  = '0;
`endif

endmodule

// File: tb/tb_ad9228_fifo_drain_sched.sv
// Randomised bench for ad9228_fifo_drain_sched with a FIFO model
// and a transaction-level round-robin reference.
module tb_ad9228_fifo_drain_sched;
  import ad9228_pkg::*;

  localparam int N  = 4;
  localparam int DW = 12;
  localparam int BL = 4;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          busy;
  logic [N-1:0]  ch_mask = '0;
  logic [N-1:0]  ovf_flags;

  ad9228_fifo_drain_sched_if #(.NUM_CHANNELS(N), .DATA_WIDTH(DW)) bus ();

  ad9228_fifo_drain_sched #(
    .NUM_CHANNELS(N),
    .DATA_WIDTH  (DW),
    .BURST_LEN   (BL),
    .RD_LATENCY  (1)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (enable),
    .ch_mask  (ch_mask),
    .ovf_clr  (ovf_clr),
    .busy     (busy),
    .ovf_flags(ovf_flags),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_pulses = 0;
  int beats = 0;
  int hs_cyc[$];
  beat_t exp_q[$];
  logic rdy_rand = 1'b0;

  logic [DW-1:0] mem [N][256];
  int wrp [N];
  int rdp [N];
  logic fifo_clr = 1'b0;

  function automatic void chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               name, act, act, req, req);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // readout FIFO model: one-cycle read latency, muxed flags
  assign bus.fifo_not_empty =
    (rdp[bus.fifo_addr] != wrp[bus.fifo_addr]);

  always @(posedge clk) begin
    if (fifo_clr) begin
      for (int c = 0; c < N; c++) rdp[c] <= 0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (bus.fifo_rd_en[c] && rdp[c] != wrp[c]) begin
          bus.fifo_dout <= mem[c][rdp[c] % 256];
          rdp[c] <= rdp[c] + 1;
        end
      end
    end
  end

  // compare process
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [DW-1:0] pd = '0;
  logic [1:0]    pc = '0;
  logic          pl = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      pv <= 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", int'(bus.m_valid), 1);
        chk("hold_data", int'(bus.m_data), int'(pd));
        chk("hold_chan", int'(bus.m_chan), int'(pc));
        chk("hold_last", int'(bus.m_last), int'(pl));
      end
      if (bus.fifo_rd_en != '0) begin
        rd_pulses++;
        chk("rd_at_addr", int'(bus.fifo_rd_en),
            1 << bus.fifo_addr);
        chk("rd_in_mask", int'(bus.fifo_rd_en & ~ch_mask), 0);
        chk("rd_while_valid", int'(bus.m_valid), 0);
        chk("rd_nonempty",
            int'(rdp[bus.fifo_addr] != wrp[bus.fifo_addr]), 1);
      end
      if (bus.m_valid && bus.m_ready) begin
        beats++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("extra_beat_expq", exp_q.size(), 1);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_chan", int'(bus.m_chan), int'(e.ch));
          chk("beat_data", int'(bus.m_data), int'(e.d));
          chk("beat_last", int'(bus.m_last), int'(e.last));
        end
      end
      pv <= bus.m_valid;
      pr <= bus.m_ready;
      pd <= bus.m_data;
      pc <= bus.m_chan;
      pl <= bus.m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) bus.m_ready = ($urandom_range(0, 99) < 65);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    enable = 1'b0;
    ovf_clr = 1'b0;
    bus.fifo_full = 1'b0;
    for (int c = 0; c < N; c++) wrp[c] = 0;
    fifo_clr = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(bus.m_valid), 0);
    chk("rst_rd_en", int'(bus.fifo_rd_en), 0);
    chk("rst_addr", int'(bus.fifo_addr), 0);
    chk("rst_data", int'(bus.m_data), 0);
    chk("rst_chan", int'(bus.m_chan), 0);
    chk("rst_last", int'(bus.m_last), 0);
    chk("rst_ovf", int'(ovf_flags), 0);
    @(posedge clk);
    #1;
    fifo_clr = 1'b0;
    exp_q.delete();
    hs_cyc.delete();
    rd_pulses = 0;
    beats = 0;
    rstn = 1'b1;
    tick();
  endtask

  task automatic load(int c, logic [DW-1:0] d);
    mem[c][wrp[c] % 256] = d;
    wrp[c] = wrp[c] + 1;
  endtask

  // expected stream: visit masked channels cyclically from
  // channel 0, taking up to BL samples per visit
  task automatic build_exp(logic [N-1:0] m);
    int rem [N];
    int idx [N];
    int left;
    int c;
    left = 0;
    c = N - 1;
    for (int k = 0; k < N; k++) begin
      rem[k] = wrp[k] - rdp[k];
      idx[k] = rdp[k];
      if (m[k]) left += rem[k];
    end
    while (left > 0) begin
      c = (c + 1) % N;
      if (m[c]) begin
        for (int j = 0; j < BL && rem[c] > 0; j++) begin
          beat_t b;
          b.ch = 2'(c);
          b.d = mem[c][idx[c] % 256];
          b.last = (j == BL - 1);
          exp_q.push_back(b);
          idx[c]++;
          rem[c]--;
          left--;
        end
      end
    end
  endtask

  task automatic drain(string name, int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      tick();
      t++;
    end
    chk({name, "_left"}, exp_q.size(), 0);
    repeat (20) tick();
  endtask

  task automatic wait_valid(string name, int budget);
    int t;
    t = 0;
    while (!bus.m_valid && t < budget) begin
      tick();
      t++;
    end
    chk({name, "_valid_seen"}, int'(bus.m_valid), 1);
  endtask

  initial begin
    int n0;
    int t;
    logic [N-1:0] m;
    bus.m_ready = 1'b1;
    bus.fifo_full = 1'b0;

    // 1: full mask, 6 samples per channel, ready held high
    do_reset();
    for (int c = 0; c < N; c++)
      for (int k = 0; k < 6; k++) load(c, 12'hA00 + 12'(k));
    ch_mask = 4'hF;
    build_exp(ch_mask);
    chk("m1_size", exp_q.size(), 24);
    chk("m1_b2_last", int'(exp_q[2].last), 0);
    chk("m1_b3_last", int'(exp_q[3].last), 1);
    chk("m1_b4_chan", int'(exp_q[4].ch), 1);
    chk("m1_b16_chan", int'(exp_q[16].ch), 0);
    chk("m1_b16_data", int'(exp_q[16].d), 'hA04);
    chk("m1_b17_last", int'(exp_q[17].last), 0);
    chk("m1_b23_chan", int'(exp_q[23].ch), 3);
    chk("m1_b23_data", int'(exp_q[23].d), 'hA05);
    enable = 1'b1;
    repeat (3) tick();
    chk("t1_lat_early", int'(bus.m_valid), 0);
    tick();
    chk("t1_lat_first", int'(bus.m_valid), 1);
    drain("t1", 400);
    chk("t1_beats", beats, 24);
    chk("t1_reads", rd_pulses, 24);
    chk("t1_period", hs_cyc[1] - hs_cyc[0], 3);
    chk("t1_switch", hs_cyc[4] - hs_cyc[3], 5);
    chk("t1_busy", int'(busy), 1);

    // 2: mask 0101, every FIFO loaded, random backpressure
    do_reset();
    for (int c = 0; c < N; c++) begin
      n0 = $urandom_range(1, 8);
      for (int k = 0; k < n0; k++) load(c, 12'($urandom));
    end
    ch_mask = 4'b0101;
    build_exp(ch_mask);
    n0 = exp_q.size();
    rdy_rand = 1'b1;
    enable = 1'b1;
    drain("t2", 2000);
    chk("t2_beats", beats, n0);
    rdy_rand = 1'b0;
    bus.m_ready = 1'b1;

    // 3: only ch2 holds 3 samples
    do_reset();
    for (int k = 0; k < 3; k++) load(2, 12'h200 + 12'(k));
    ch_mask = 4'hF;
    build_exp(ch_mask);
    chk("m3_size", exp_q.size(), 3);
    chk("m3_b2_last", int'(exp_q[2].last), 0);
    enable = 1'b1;
    drain("t3", 200);
    chk("t3_reads", rd_pulses, 3);
    chk("t3_busy", int'(busy), 1);

    // 4: 10-cycle stall while a beat is presented
    do_reset();
    for (int k = 0; k < 4; k++) load(1, 12'($urandom));
    for (int k = 0; k < 2; k++) load(0, 12'($urandom));
    ch_mask = 4'hF;
    build_exp(ch_mask);
    bus.m_ready = 1'b0;
    enable = 1'b1;
    wait_valid("t4", 50);
    n0 = rd_pulses;
    repeat (10) tick();
    chk("t4_stall_reads", rd_pulses, n0);
    chk("t4_stall_valid", int'(bus.m_valid), 1);
    bus.m_ready = 1'b1;
    drain("t4", 200);

    // 5: enable dropped in WAIT, then reset during HOLD
    do_reset();
    for (int k = 0; k < 5; k++) load(1, 12'h150 + 12'(k));
    ch_mask = 4'b0010;
    begin
      beat_t b;
      b.ch = 2'd1;
      b.d = 12'h150;
      b.last = 1'b0;
      exp_q.push_back(b);
    end
    enable = 1'b1;
    t = 0;
    while (bus.fifo_rd_en == '0 && t < 50) begin
      tick();
      t++;
    end
    chk("t5_rd_seen", int'(bus.fifo_rd_en), 2);
    tick();
    enable = 1'b0;
    wait_valid("t5", 20);
    tick();
    tick();
    chk("t5_idle", int'(busy), 0);
    chk("t5_left", exp_q.size(), 0);
    repeat (10) tick();
    chk("t5_reads", rd_pulses, 1);
    bus.m_ready = 1'b0;
    enable = 1'b1;
    wait_valid("t5b", 50);
    rstn = 1'b0;
    #1;
    chk("t5_rst_valid", int'(bus.m_valid), 0);
    chk("t5_rst_rd", int'(bus.fifo_rd_en), 0);
    chk("t5_rst_busy", int'(busy), 0);
    bus.m_ready = 1'b1;

    // random scenarios
    for (int s = 0; s < 5; s++) begin
      do_reset();
      m = 4'($urandom_range(1, 15));
      for (int c = 0; c < N; c++) begin
        n0 = $urandom_range(0, 7);
        for (int k = 0; k < n0; k++) load(c, 12'($urandom));
      end
      ch_mask = m;
      build_exp(ch_mask);
      n0 = exp_q.size();
      rdy_rand = 1'b1;
      enable = 1'b1;
      drain("rnd", 2000);
      chk("rnd_beats", beats, n0);
      rdy_rand = 1'b0;
      bus.m_ready = 1'b1;
    end

    // 6: overflow flags
    do_reset();
    ch_mask = 4'b1000;
    enable = 1'b1;
    repeat (3) tick();
    chk("t6_addr", int'(bus.fifo_addr), 3);
    bus.fifo_full = 1'b1;
    ovf_clr = 1'b1;
    tick();
    bus.fifo_full = 1'b0;
    ovf_clr = 1'b0;
`ifdef AD9228_DRAIN_OVF_EN
    chk("t6_ovf_set", int'(ovf_flags), 8);
`else
    chk("t6_ovf_off", int'(ovf_flags), 0);
`endif
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t6_ovf_clr", int'(ovf_flags), 0);
    enable = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
